// File: rtl/dump_pkg.sv
// ============================================================================
// Module : dump_pkg
// Brief  : Shared types for the end-of-run dump sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dump_pkg;

    typedef enum logic [1:0] {
        KIND_PC  = 2'd0,
        KIND_REG = 2'd1,
        KIND_MEM = 2'd2
    } kind_t;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_ZERO_INST = 2'd1,
        CAUSE_TIMEOUT   = 2'd2
    } cause_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DUMP_REG = 2'd1,
        ST_DUMP_MEM = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cycle_budget_counter.sv
// ============================================================================
// Module : cycle_budget_counter
// Brief  : Run-cycle counter that flags expiry on cycle TIMEOUT_CYCLES-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cycle_budget_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_CNT_W-1:0] r_count;

    assign o_expired = (r_count == c_CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates on expiry so the count never wraps back below the budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dump_sequencer.sv
// ============================================================================
// Module : dump_sequencer
// Brief  : PC trace while running, then register-file and memory-window dump.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dump_sequencer
    import dump_pkg::*;
#(
    parameter int                 DATA_W         = 32,
    parameter int                 NUM_REGS       = 32,
    parameter int                 RF_AW          = 5,
    parameter int                 MEM_AW         = 32,
    parameter logic [MEM_AW-1:0]  MEM_BASE       = 'h4000,
    parameter int                 MEM_WORDS      = 4,
    parameter int                 TIMEOUT_CYCLES = 64,
    parameter int                 TRACE_PC       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] inst,
    output logic [RF_AW-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_kind,
    output logic              out_last,
    output logic              halted,
    output logic              done,
    output logic [1:0]        halt_cause,
    output logic              trace_drop
);

    localparam int c_IDX_MAX  = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
    localparam int c_IDX_W    = (c_IDX_MAX > 1) ? $clog2(c_IDX_MAX) : 1;
    localparam int c_MEM_LAST = (MEM_WORDS > 0) ? MEM_WORDS - 1 : 0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  w_idx_nxt;
    cause_t              r_cause;
    logic                r_trace_drop;

    logic                w_in_run;
    logic                w_expired;
    logic                w_zero_inst;
    logic                w_reg_end;
    logic                w_mem_end;
    logic                w_valid;
    logic [DATA_W-1:0]   w_data;
    kind_t               w_kind;
    logic                w_last;
    logic [RF_AW-1:0]    w_rf_addr;
    logic [MEM_AW-1:0]   w_mem_addr;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_zero_inst = (inst == '0);
    assign w_reg_end   = (r_idx == c_IDX_W'(NUM_REGS - 1));
    assign w_mem_end   = (r_idx == c_IDX_W'(c_MEM_LAST));

    cycle_budget_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_budget (
        .clk       (clk),
        .rst       (reset),
        .i_en      (w_in_run),
        .i_clr     (!w_in_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_idx        <= '0;
            r_cause      <= CAUSE_NONE;
            r_trace_drop <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_in_run && (w_zero_inst || w_expired)) begin
                r_cause <= w_zero_inst ? CAUSE_ZERO_INST : CAUSE_TIMEOUT;
            end
            if (w_in_run && (TRACE_PC != 0) && !out_ready) begin
                r_trace_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid     = 1'b0;
        w_data      = '0;
        w_kind      = KIND_PC;
        w_last      = 1'b0;
        w_rf_addr   = '0;
        w_mem_addr  = '0;
        case (r_state)
            ST_RUN: begin
                // Trace beats are fire-and-forget; the machine never waits on the sink.
                w_valid = (TRACE_PC != 0);
                w_data  = pc;
                if (w_zero_inst || w_expired) begin
                    w_state_nxt = ST_DUMP_REG;
                end
            end
            ST_DUMP_REG: begin
                w_valid   = 1'b1;
                w_rf_addr = RF_AW'(r_idx);
                w_data    = rf_rdata;
                w_kind    = KIND_REG;
                w_last    = (MEM_WORDS == 0) && w_reg_end;
                if (out_ready) begin
                    if (w_reg_end) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (MEM_WORDS == 0) ? ST_DONE : ST_DUMP_MEM;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_DUMP_MEM: begin
                w_valid    = 1'b1;
                w_mem_addr = MEM_BASE + MEM_AW'(r_idx);
                w_data     = mem_rdata;
                w_kind     = KIND_MEM;
                w_last     = w_mem_end;
                if (out_ready) begin
                    if (w_mem_end) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Reset forces the state to RUN asynchronously, so only the RUN-phase beat needs gating.
    assign out_valid  = w_valid & ~reset;
    assign out_data   = reset ? '0 : w_data;
    assign out_kind   = w_kind;
    assign out_last   = w_last;
    assign rf_raddr   = w_rf_addr;
    assign mem_raddr  = w_mem_addr;
    assign halted     = !w_in_run;
    assign done       = (r_state == ST_DONE);
    assign halt_cause = r_cause;
    assign trace_drop = r_trace_drop;

endmodule

`default_nettype wire

// File: tb/tb_dump_sequencer.sv
// ============================================================================
// Module : tb_dump_sequencer
// Brief  : Scoreboard bench for dump_sequencer (default and small-RF configs).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dump_sequencer;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  kind;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ready_a;
    logic        ready_b;

    logic [4:0]  a_rf_raddr;
    logic [31:0] a_rf_rdata;
    logic [31:0] a_mem_raddr;
    logic [31:0] a_mem_rdata;
    logic        a_valid;
    logic [31:0] a_data;
    logic [1:0]  a_kind;
    logic        a_last;
    logic        a_halted;
    logic        a_done;
    logic [1:0]  a_cause;
    logic        a_drop;

    logic [2:0]  b_rf_raddr;
    logic [31:0] b_rf_rdata;
    logic [31:0] b_mem_raddr;
    logic [31:0] b_mem_rdata;
    logic        b_valid;
    logic [31:0] b_data;
    logic [1:0]  b_kind;
    logic        b_last;
    logic        b_halted;
    logic        b_done;
    logic [1:0]  b_cause;
    logic        b_drop;

    beat_t       qa[$];
    beat_t       qb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic        chk_a;
    logic        chk_b;
    logic        stall_prev;
    logic [4:0]  prev_rf;
    logic [31:0] prev_mem;
    logic [1:0]  prev_kind;
    logic        prev_last;

    always #5 clk = ~clk;

    assign a_rf_rdata  = 32'hA500_0000 | 32'(a_rf_raddr);
    assign a_mem_rdata = 32'h5A00_0000 ^ a_mem_raddr;
    assign b_rf_rdata  = 32'hB0B0_0000 | 32'(b_rf_raddr);
    assign b_mem_rdata = 32'hDEAD_BEEF;

    dump_sequencer dut_a (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .inst       (inst),
        .rf_raddr   (a_rf_raddr),
        .rf_rdata   (a_rf_rdata),
        .mem_raddr  (a_mem_raddr),
        .mem_rdata  (a_mem_rdata),
        .out_valid  (a_valid),
        .out_ready  (ready_a),
        .out_data   (a_data),
        .out_kind   (a_kind),
        .out_last   (a_last),
        .halted     (a_halted),
        .done       (a_done),
        .halt_cause (a_cause),
        .trace_drop (a_drop)
    );

    dump_sequencer #(
        .NUM_REGS  (8),
        .RF_AW     (3),
        .MEM_WORDS (0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .inst       (inst),
        .rf_raddr   (b_rf_raddr),
        .rf_rdata   (b_rf_rdata),
        .mem_raddr  (b_mem_raddr),
        .mem_rdata  (b_mem_rdata),
        .out_valid  (b_valid),
        .out_ready  (ready_b),
        .out_data   (b_data),
        .out_kind   (b_kind),
        .out_last   (b_last),
        .halted     (b_halted),
        .done       (b_done),
        .halt_cause (b_cause),
        .trace_drop (b_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic [1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.kind = k;
        b.last = l;
        return b;
    endfunction

    // Called at a falling edge with inputs already driven; samples, then waits one cycle.
    task automatic cyc();
        beat_t e;
        #1;
        if (chk_a && a_valid && ready_a) begin
            chk("a_beat_expected", 64'(qa.size() != 0), 64'(1));
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_data", 64'(a_data), 64'(e.data));
                chk("a_kind", 64'(a_kind), 64'(e.kind));
                chk("a_last", 64'(a_last), 64'(e.last));
            end
        end
        if (chk_a && stall_prev && a_halted) begin
            chk("a_rf_addr_stable", 64'(a_rf_raddr), 64'(prev_rf));
            chk("a_mem_addr_stable", 64'(a_mem_raddr), 64'(prev_mem));
            chk("a_kind_stable", 64'(a_kind), 64'(prev_kind));
            chk("a_last_stable", 64'(a_last), 64'(prev_last));
        end
        stall_prev = chk_a && a_valid && !ready_a && a_halted;
        prev_rf    = a_rf_raddr;
        prev_mem   = a_mem_raddr;
        prev_kind  = a_kind;
        prev_last  = a_last;
        if (chk_b && b_valid && ready_b) begin
            chk("b_beat_expected", 64'(qb.size() != 0), 64'(1));
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_data", 64'(b_data), 64'(e.data));
                chk("b_kind", 64'(b_kind), 64'(e.kind));
                chk("b_last", 64'(b_last), 64'(e.last));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        qa.delete();
        qb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_dump_a();
        for (int r = 0; r < 32; r++) qa.push_back(mk(32'hA500_0000 | 32'(r), 2'd1, 1'b0));
        for (int m = 0; m < 4; m++) qa.push_back(mk(32'h5A00_0000 ^ (32'h4000 + 32'(m)), 2'd2, m == 3));
    endtask

    // mode 1 drives ready with the repeating pattern 1,0,0,1.
    task automatic drain_a(input int budget, input int mode, input int keep);
        for (int k = 0; k < budget && qa.size() > keep; k++) begin
            ready_a = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            cyc();
        end
        ready_a = 1'b1;
        chk("a_drain_left", 64'(qa.size()), 64'(keep));
    endtask

    initial begin
        reset   = 1'b1;
        pc      = 32'h10;
        inst    = 32'h13;
        ready_a = 1'b1;
        ready_b = 1'b1;
        chk_a   = 1'b1;
        chk_b   = 1'b0;
        stall_prev = 1'b0;
        prev_rf = '0; prev_mem = '0; prev_kind = '0; prev_last = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(a_valid), 64'(0));
        chk("rst_data", 64'(a_data), 64'(0));
        chk("rst_halted", 64'(a_halted), 64'(0));
        chk("rst_done", 64'(a_done), 64'(0));
        chk("rst_cause", 64'(a_cause), 64'(0));
        chk("rst_drop", 64'(a_drop), 64'(0));
        chk("rst_rf_addr", 64'(a_rf_raddr), 64'(0));
        chk("rst_mem_addr", 64'(a_mem_raddr), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Short program halted by a zero instruction.
        for (int i = 0; i < 4; i++) begin
            pc   = 32'(i * 4);
            inst = (i == 3) ? 32'h0 : 32'h13 + 32'(i);
            qa.push_back(mk(32'(i * 4), 2'd0, 1'b0));
            cyc();
        end
        chk("t1_halted", 64'(a_halted), 64'(1));
        chk("t1_cause", 64'(a_cause), 64'(1));
        push_dump_a();
        drain_a(100, 0, 0);
        chk("t1_done", 64'(a_done), 64'(1));
        chk("t1_valid_done", 64'(a_valid), 64'(0));
        chk("t1_drop", 64'(a_drop), 64'(0));

        // Timeout: 64 PC beats, never a zero instruction.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("t2_not_halted_63", 64'(a_halted), 64'(0));
            pc   = 32'(i * 4);
            inst = 32'h33;
            qa.push_back(mk(32'(i * 4), 2'd0, 1'b0));
            cyc();
        end
        chk("t2_halted", 64'(a_halted), 64'(1));
        chk("t2_cause", 64'(a_cause), 64'(2));
        push_dump_a();
        drain_a(100, 0, 0);
        chk("t2_done", 64'(a_done), 64'(1));

        // Zero instruction on the timeout cycle, then a stalling register dump.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            pc   = 32'(i * 4);
            inst = (i == 63) ? 32'h0 : 32'h33;
            qa.push_back(mk(32'(i * 4), 2'd0, 1'b0));
            cyc();
        end
        chk("t3_cause", 64'(a_cause), 64'(1));
        push_dump_a();
        drain_a(300, 1, 0);
        chk("t4_done", 64'(a_done), 64'(1));

        // Small RF, no memory window; trace dropped while the sink is idle.
        do_reset();
        chk_a   = 1'b0;
        chk_b   = 1'b1;
        ready_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc   = 32'(i * 4);
            inst = (i == 2) ? 32'h0 : 32'h13;
            cyc();
        end
        chk("t5_drop", 64'(b_drop), 64'(1));
        chk("t5_cause", 64'(b_cause), 64'(1));
        ready_b = 1'b1;
        for (int r = 0; r < 8; r++) qb.push_back(mk(32'hB0B0_0000 | 32'(r), 2'd1, r == 7));
        for (int k = 0; k < 40 && qb.size() > 0; k++) cyc();
        chk("t5_drain_left", 64'(qb.size()), 64'(0));
        cyc();
        chk("t5_done", 64'(b_done), 64'(1));
        chk("t5_no_mem_beat", 64'(b_valid), 64'(0));
        chk_b = 1'b0;

        // Reset in the middle of the memory phase.
        do_reset();
        chk_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc   = 32'(i * 4);
            inst = (i == 2) ? 32'h0 : 32'h13;
            qa.push_back(mk(32'(i * 4), 2'd0, 1'b0));
            cyc();
        end
        push_dump_a();
        drain_a(100, 0, 2);
        chk("t6_pre_kind", 64'(a_kind), 64'(2));
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(a_valid), 64'(0));
        chk("t6_rst_data", 64'(a_data), 64'(0));
        chk("t6_rst_kind", 64'(a_kind), 64'(0));
        chk("t6_rst_mem_addr", 64'(a_mem_raddr), 64'(0));
        chk("t6_rst_halted", 64'(a_halted), 64'(0));
        chk("t6_rst_cause", 64'(a_cause), 64'(0));
        qa.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pc    = 32'h0;
        inst  = 32'h13;
        qa.push_back(mk(32'h0, 2'd0, 1'b0));
        cyc();
        chk("t6_post_left", 64'(qa.size()), 64'(0));
        chk("t6_post_done", 64'(a_done), 64'(0));
        chk("t6_post_cause", 64'(a_cause), 64'(0));
        chk("t6_post_halted", 64'(a_halted), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
